// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: sequential square-and-multiply engine, Result = Msg^Exp mod Mod.
// Drives the select of an external N-bit 2:1 operand MUX and consumes its output.
// The MUX returns the running residue R when sel=0 (square) and Msg when sel=1 (multiply).
// The modular product is formed bit-serially by an interleaved shift-add multiplier.
//
// Optional feature macro: RSA_CONST_TIME_EN. When it is defined, MUL runs for every
// exponent bit and discards the product for clear bits, so latency is fixed.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only in IDLE
//   Msg      base, latched on accept
//   Exp      exponent, latched on accept
//   Mod      modulus, latched on accept
//   sel      operand-MUX select (0 = R, 1 = Msg)
//   mux_out  operand-MUX output
//   busy     high from accept through the done cycle
//   done     one-cycle pulse; Result and err are valid
//   err      illegal-operand flag, held until the next accept
//   Result   residue, held until the next done
module rsa_modexp_ctrl #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] Msg,
    input  logic [N-1:0] Exp,
    input  logic [N-1:0] Mod,
    output logic         sel,
    input  logic [N-1:0] mux_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] Result
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] SQR   = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state_q;
    logic [N-1:0]  msg_q, exp_q, mod_q;
    logic [N-1:0]  r_q;
    logic [N:0]    p_q;
    logic [IW-1:0] idx_q;   // exponent bit being processed
    logic [IW-1:0] step_q;  // multiplier bit of R being consumed

    logic [N:0]    p_dbl, p_add;
    logic [N-1:0]  r_new;
    logic          go_mul, last_bit;

    // One interleaved multiplier step. P < Mod on entry, so every value fits N+1 bits.
    always_comb begin
        p_dbl = p_q + p_q;
        if (p_dbl >= {1'b0, mod_q}) p_dbl = p_dbl - {1'b0, mod_q};
        p_add = p_dbl;
        if (r_q[step_q]) begin
            p_add = p_dbl + {1'b0, mux_out};
            if (p_add >= {1'b0, mod_q}) p_add = p_add - {1'b0, mod_q};
        end
    end

    always_comb begin
        r_new = p_add[N-1:0];
        // Only reachable with constant-time MUL: a clear bit keeps R.
        if (state_q == MUL && !exp_q[idx_q]) r_new = r_q;
        last_bit = (idx_q == '0);
`ifdef RSA_CONST_TIME_EN
        go_mul = 1'b1;
`else
        go_mul = exp_q[idx_q];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            r_q     <= '0;
            p_q     <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            sel     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            Result  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        msg_q   <= Msg;
                        exp_q   <= Exp;
                        mod_q   <= Mod;
                        err     <= 1'b0;
                        r_q     <= N'(1);
                        idx_q   <= IW'(N - 1);
                        busy    <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (mod_q == '0 || msg_q >= mod_q) begin
                        err     <= 1'b1;
                        Result  <= '0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else if (mod_q == N'(1)) begin
                        Result  <= '0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        sel     <= 1'b0;
                        p_q     <= '0;
                        step_q  <= IW'(N - 1);
                        state_q <= SQR;
                    end
                end
                SQR, MUL: begin
                    if (step_q != '0) begin
                        p_q    <= p_add;
                        step_q <= step_q - IW'(1);
                    end else begin
                        // Last step of this product: commit R and pick the next operation.
                        r_q    <= r_new;
                        p_q    <= '0;
                        step_q <= IW'(N - 1);
                        if (state_q == SQR && go_mul) begin
                            sel     <= 1'b1;
                            state_q <= MUL;
                        end else if (!last_bit) begin
                            idx_q   <= idx_q - IW'(1);
                            sel     <= 1'b0;
                            state_q <= SQR;
                        end else begin
                            Result  <= r_new;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl: self-checking bench for rsa_modexp_ctrl (N = 6).
// The bench plays the operand MUX: mux_out = sel ? latched Msg : expected R.
// Expected results come from repeated modular multiplication; latency and the
// expected R/sel per operation come from the square-and-multiply schedule.
module tb_rsa_modexp_ctrl;

    localparam int N = 6;
`ifdef RSA_CONST_TIME_EN
    localparam bit ConstTime = 1'b1;
`else
    localparam bit ConstTime = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] Msg = '0, Exp = '0, Mod = '0;
    logic         sel;
    logic [N-1:0] mux_out;
    logic         busy, done, err;
    logic [N-1:0] Result;

    logic [N-1:0] msg_m = '0;
    logic [N-1:0] r_model = '0;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb mux_out = sel ? msg_m : r_model;

    rsa_modexp_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .Msg     (Msg),
        .Exp     (Exp),
        .Mod     (Mod),
        .sel     (sel),
        .mux_out (mux_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .Result  (Result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // One transaction. poke: hammer start and scramble inputs while busy.
    // abort_at > 0: pull rst_n low just before that edge and stop.
    task automatic run(input int m, input int e, input int md, input bit poke,
                       input int abort_at, input string name);
        int rseq [0:2*N-1];
        bit opsel [0:2*N-1];
        int nops, lat, r, res, k;
        bit xerr;

        if (md == 0 || m >= md) begin
            xerr = 1'b1;
            res  = 0;
        end else begin
            xerr = 1'b0;
            if (md == 1) res = 0;
            else begin
                res = 1;
                for (int i = 0; i < e; i++) res = (res * m) % md;
            end
        end

        nops = 0;
        r = 1;
        if (!xerr && md > 1) begin
            for (int b = N - 1; b >= 0; b--) begin
                rseq[nops] = r; opsel[nops] = 1'b0; nops++;
                r = (r * r) % md;
                if (((e >> b) & 1) == 1 || ConstTime) begin
                    rseq[nops] = r; opsel[nops] = 1'b1; nops++;
                    if (((e >> b) & 1) == 1) r = (r * m) % md;
                end
            end
        end
        lat = 1 + N * nops;

        @(negedge clk);
        Msg = m[N-1:0]; Exp = e[N-1:0]; Mod = md[N-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        msg_m = m[N-1:0];
        r_model = N'(1);
        check({name, "/busy_accept"}, busy, 1);
        check({name, "/done_accept"}, done, 0);

        for (int ed = 1; ed <= lat + 1; ed++) begin
            if (ed == abort_at) begin
                @(negedge clk);
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check({name, "/busy_rst"}, busy, 0);
                check({name, "/done_rst"}, done, 0);
                check({name, "/result_rst"}, Result, 0);
                check({name, "/err_rst"}, err, 0);
                check({name, "/sel_rst"}, sel, 0);
                @(posedge clk); #1;
                check({name, "/busy_rst_hold"}, busy, 0);
                check({name, "/done_rst_hold"}, done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (ed < lat) begin
                check({name, "/busy_run"}, busy, 1);
                check({name, "/done_run"}, done, 0);
                k = (ed - 1) / N;
                check({name, "/sel_run"}, sel, opsel[k]);
                r_model = rseq[k][N-1:0];
            end else if (ed == lat) begin
                check({name, "/done_pulse"}, done, 1);
                check({name, "/busy_done"}, busy, 1);
                check({name, "/result"}, Result, res);
                check({name, "/err"}, err, xerr);
            end else begin
                check({name, "/done_fall"}, done, 0);
                check({name, "/busy_fall"}, busy, 0);
                check({name, "/result_hold"}, Result, res);
                check({name, "/err_hold"}, err, xerr);
            end
            if (poke) begin
                start = (ed >= lat) ? 1'b1 : 1'($urandom_range(0, 1));
                Msg = N'($urandom);
                Exp = N'($urandom);
                Mod = N'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int md, m, e;

        #12;
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/err", err, 0);
        check("reset/sel", sel, 0);
        check("reset/result", Result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(13, 27, 55, 1'b0, 0, "m13e27");
        run(7, 3, 55, 1'b1, 0, "m7e3_poke");
        run(2, 5, 35, 1'b0, 0, "m2e5_b2b");
        run(9, 0, 55, 1'b0, 0, "exp0");
        run(0, 5, 55, 1'b0, 0, "msg0");
        run(5, 3, 0, 1'b0, 0, "mod0");
        run(40, 7, 33, 1'b0, 0, "msg_ge_mod");
        run(0, 3, 1, 1'b0, 0, "mod1");
        run(13, 27, 55, 1'b0, 20, "abort");
        run(13, 27, 55, 1'b0, 0, "after_rst");

        for (int t = 0; t < 6; t++) begin
            md = int'($urandom_range(2, 63));
            m  = int'($urandom_range(0, md - 1));
            e  = int'($urandom_range(0, 63));
            run(m, e, md, 1'($urandom_range(0, 1)), 0, "rand");
        end
        for (int t = 0; t < 2; t++) begin
            md = int'($urandom_range(1, 63));
            m  = int'($urandom_range(md, 63));
            run(m, 3, md, 1'b0, 0, "rand_err");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
